rand_index_arbiter: RTL and testbench

RAND_INDEX_ARBITER -- requirements
Module: rand_index_arbiter

---
 rtl/rand_index_arbiter.sv | 159 +++++++++++++++
 tb/tb_rand_index_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rand_index_arbiter.sv
// rand_index_arbiter
//
// Purpose: two requesters share one pseudo-random index generator. A
// round-robin arbiter picks one requester and samples its exclusive upper
// bound. The FSM then draws candidates from a free-running 16-bit Fibonacci
// LFSR by rejection sampling until one falls below the bound. If 16
// consecutive candidates are rejected, it returns index 0 and raises
// fallback. A zero bound short-circuits to index 0 with err_limit.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   seed_load  in   load seed into the LFSR on this edge (0 -> SEED_RST)
//   seed       in   16-bit seed value
//   limit      in   exclusive upper bound, sampled at grant
//   req        in   per-requester draw request
//   ack        out  one-hot grant-complete pulse (one cycle, in DONE)
//   index      out  drawn index, valid with ack and held afterwards
//   busy       out  high while in DRAW or DONE
//   fallback   out  pulses with ack when the rejection budget ran out
//   err_limit  out  pulses with ack when the sampled limit was zero
//
// Handshake: a requester raises req and holds it until it sees its ack bit.
// ack is a single-cycle pulse that completes the transaction. Dropping req
// early does not cancel a draw in flight; ack still pulses once. A requester
// still holding req after ack is treated as a new request.

module rand_index_arbiter #(
  parameter int          IDX_W    = 12,
  parameter logic [15:0] SEED_RST = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  input  logic [IDX_W-1:0] limit,
  input  logic [1:0]       req,
  output logic [1:0]       ack,
  output logic [IDX_W-1:0] index,
  output logic             busy,
  output logic             fallback,
  output logic             err_limit
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [15:0]      lfsr_q,    lfsr_d;
  logic             ptr_q,     ptr_d;
  logic             grant_q,   grant_d;
  logic [IDX_W-1:0] limit_q,   limit_d;
  logic [3:0]       attempt_q, attempt_d;
  logic [IDX_W-1:0] index_q,   index_d;
  logic             fb_q,      fb_d;
  logic             err_q,     err_d;

  logic [IDX_W-1:0] candidate;

  // The LFSR runs every edge regardless of FSM state. A seed of zero would
  // lock the register at zero, so it is replaced by SEED_RST.
  always_comb begin
    if (seed_load) begin
      lfsr_d = (seed == 16'h0000) ? SEED_RST : seed;
    end else begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // The candidate comes from the pre-edge LFSR value, so a seed load in the
  // same cycle only affects the next comparison.
  assign candidate = lfsr_q[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    limit_d   = limit_q;
    attempt_d = attempt_q;
    index_d   = index_q;
    fb_d      = fb_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          // Both active: the pointer decides. One active: it wins.
          grant_d   = (req == 2'b11) ? ptr_q : req[1];
          limit_d   = limit;
          attempt_d = 4'd0;
          if (limit == '0) begin
            index_d = '0;
            fb_d    = 1'b0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAW;
          end
        end
      end
      ST_DRAW: begin
        if (candidate < limit_q) begin
          index_d = candidate;
          fb_d    = 1'b0;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (attempt_q == 4'd15) begin
          // This is the 16th rejection in a row: give up with index 0.
          index_d = '0;
          fb_d    = 1'b1;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          attempt_d = attempt_q + 4'd1;
        end
      end
      ST_DONE: begin
        // Hand priority to the requester that was not just served.
        ptr_d   = ~grant_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED_RST;
      ptr_q     <= 1'b0;
      grant_q   <= 1'b0;
      limit_q   <= '0;
      attempt_q <= 4'd0;
      index_q   <= '0;
      fb_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      limit_q   <= limit_d;
      attempt_q <= attempt_d;
      index_q   <= index_d;
      fb_q      <= fb_d;
      err_q     <= err_d;
    end
  end

  // The pulse outputs are decoded from the state, so they are low outside DONE.
  assign busy      = (state_q != ST_IDLE);
  assign ack       = (state_q == ST_DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign fallback  = (state_q == ST_DONE) && fb_q;
  assign err_limit = (state_q == ST_DONE) && err_q;
  assign index     = index_q;

endmodule

// File: tb/tb_rand_index_arbiter.sv
// Testbench for rand_index_arbiter: directed steps plus a short random tail.
// A reference LFSR and round-robin pointer predict each draw. The prediction
// is pushed to a queue when the request is driven and popped when ack appears.

module tb_rand_index_arbiter;

  localparam logic [15:0] SEED_RST = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [11:0] limit = 12'h000;
  logic [1:0]  req = 2'b00;
  logic [1:0]  ack;
  logic [11:0] index;
  logic        busy;
  logic        fallback;
  logic        err_limit;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  int          lat_q[$];

  // Model state
  logic [15:0] m_lfsr = SEED_RST;
  logic        m_ptr  = 1'b0;

  rand_index_arbiter #(.IDX_W(12), .SEED_RST(SEED_RST)) dut (
    .clock(clock), .reset(reset), .seed_load(seed_load), .seed(seed),
    .limit(limit), .req(req), .ack(ack), .index(index), .busy(busy),
    .fallback(fallback), .err_limit(err_limit)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model helpers ----------------
  function automatic logic [15:0] nxt(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, mirrored in the model, then settle for sampling.
  task automatic tick();
    @(posedge clock);
    if (!reset)          m_lfsr = SEED_RST;
    else if (seed_load)  m_lfsr = (seed == 16'h0000) ? SEED_RST : seed;
    else                 m_lfsr = nxt(m_lfsr);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    m_lfsr = SEED_RST;
    m_ptr  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Issue one request with the DUT in IDLE. mid[0] drops req after the
  // grant edge, and mid[1] changes limit after the grant edge.
  task automatic do_draw(input string tag, input logic [1:0] r, input logic [11:0] lim,
                         input logic [1:0] mid, output logic [1:0] obs_ack);
    logic [15:0] l;
    logic [11:0] e_idx;
    logic        e_fb, e_err, g, seen;
    int          e_lat, lat;
    logic [15:0] e_rec;
    req   = r;
    limit = lim;
    g     = (r == 2'b11) ? m_ptr : r[1];
    l     = nxt(m_lfsr);
    e_idx = 12'h000; e_err = 1'b0; e_fb = 1'b0; e_lat = 1;
    if (lim == 12'h000) begin
      e_err = 1'b1;
    end else begin
      e_fb = 1'b1; e_lat = 17;
      for (int n = 0; n < 16; n++) begin
        if (l[11:0] < lim) begin
          e_idx = l[11:0]; e_fb = 1'b0; e_lat = n + 2;
          break;
        end
        l = nxt(l);
      end
    end
    exp_q.push_back({(g ? 2'b10 : 2'b01), e_idx, e_fb, e_err});
    lat_q.push_back(e_lat);

    lat = 0; seen = 1'b0; obs_ack = 2'b00;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        if (mid[0]) req = 2'b00;
        if (mid[1]) limit = 12'h001;
      end
      if (ack != 2'b00) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
    e_rec = exp_q.pop_front();
    e_lat = lat_q.pop_front();
    if (seen) begin
      obs_ack = ack;
      check({tag, "_result"}, {16'd0, ack, index, fallback, err_limit}, {16'd0, e_rec});
      check({tag, "_latency"}, lat, e_lat);
      m_ptr = ~g;
      tick();
      check({tag, "_idle"}, {28'd0, ack, busy, fallback | err_limit}, 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [1:0] a;
  logic [1:0] rr_r;
  logic [11:0] rl;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_outputs", {15'd0, ack, index, busy, fallback, err_limit}, 32'd0);
    check("rst_lfsr", {16'd0, dut.lfsr_q}, {16'd0, SEED_RST});

    // Basic draw straight out of reset: index 9C3 after edge 2
    req = 2'b01; limit = 12'hFFF;
    reset = 1'b1;
    do_draw("basic", 2'b01, 12'hFFF, 2'b00, a);
    check("basic_ack_const", {30'd0, a}, 32'd1);
    check("basic_idx_const", {20'd0, index}, 32'h9C3);

    // Round robin with both requesting from reset release
    do_reset();
    do_draw("rr1", 2'b11, 12'hFFF, 2'b00, a);
    check("rr1_ack_const", {30'd0, a}, 32'd1);
    do_draw("rr2", 2'b11, 12'hFFF, 2'b00, a);
    check("rr2_ack_const", {30'd0, a}, 32'd2);
    do_draw("rr3", 2'b11, 12'hFFF, 2'b00, a);
    check("rr3_ack_const", {30'd0, a}, 32'd1);
    do_draw("rr4", 2'b11, 12'h800, 2'b00, a);
    check("rr4_ack_const", {30'd0, a}, 32'd2);
    req = 2'b00;

    // Zero limit: straight to DONE with err_limit
    do_draw("zero", 2'b10, 12'h000, 2'b00, a);
    check("zero_idx_const", {20'd0, index}, 32'h0);

    // Rejection budget: tight limits exercise the fallback path
    do_draw("lim1_a", 2'b01, 12'h001, 2'b00, a);
    check("lim1_a_idx_const", {20'd0, index}, 32'h0);
    do_draw("lim1_b", 2'b10, 12'h001, 2'b00, a);
    check("lim1_b_idx_const", {20'd0, index}, 32'h0);
    do_draw("lim3", 2'b01, 12'h003, 2'b00, a);
    do_draw("lim400", 2'b10, 12'h400, 2'b00, a);

    // req dropped after grant, and limit changed after grant
    do_draw("drop", 2'b01, 12'h200, 2'b01, a);
    do_draw("limchg", 2'b10, 12'h100, 2'b10, a);
    do_draw("both", 2'b11, 12'h080, 2'b11, a);

    // Seeding
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    check("seed_zero", {16'd0, dut.lfsr_q}, {16'd0, SEED_RST});
    seed = 16'h0001;
    tick();
    check("seed_one", {16'd0, dut.lfsr_q}, 32'h0001);
    seed_load = 1'b0;
    do_draw("seeded", 2'b01, 12'hFFF, 2'b00, a);
    check("seeded_idx_const", {20'd0, index}, 32'h002);

    // Reset in the middle of a draw
    req = 2'b01; limit = 12'h001;
    tick();
    tick();
    #2;
    reset = 1'b0;
    m_lfsr = SEED_RST;
    m_ptr  = 1'b0;
    #1;
    check("midrst_outputs", {15'd0, ack, index, busy, fallback, err_limit}, 32'd0);
    check("midrst_lfsr", {16'd0, dut.lfsr_q}, {16'd0, SEED_RST});
    req = 2'b00;
    tick();
    check("midrst_hold", {15'd0, ack, index, busy, fallback, err_limit}, 32'd0);
    reset = 1'b1;
    check("midrst_rel_lfsr", {16'd0, dut.lfsr_q}, {16'd0, SEED_RST});
    tick();
    check("midrst_step_lfsr", {16'd0, dut.lfsr_q}, 32'h59C3);
    check("midrst_no_ack", {30'd0, ack}, 32'd0);

    // Random tail
    for (int k = 0; k < 24; k++) begin
      rr_r = 2'($urandom_range(1, 3));
      rl   = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
      do_draw("rnd", rr_r, rl, 2'($urandom_range(0, 3)), a);
      req = 2'b00;
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
